chunyi_ctrl: RTL and testbench
==============================

// Module: chunyi_ctrl
// PURPOSE
//  Player-character controller for Chun-Yi. Turns debounced direction/attack keys and a frame tick
//  into the character state code and position. Sits directly upstream of the weapon stage, which
//  consumes state/pos_h/pos_v as state_CY/pos_h_CY/pos_v_CY. Attack codes 4'hA-4'hD drive weapon spawning.
// PARAMETERS
//  H_INIT   320  reset/initial horizontal position (pixels)
//  V_INIT   240  reset/initial vertical position
//  H_MIN    20   lowest legal pos_h; keeps the +/-20 weapon offset on screen
//  H_MAX    619  highest legal pos_h
//  V_MIN    20   lowest legal pos_v
//  V_MAX    459  highest legal pos_v
//  STEP     2    pixels moved per tick while walking
//  ATK_TICKS 15  ticks an attack state is held
//  CD_TICKS 10   cooldown ticks after an attack before a new one is accepted
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous, active-high reset
//  tick      in   1   1-cycle frame pulse; all motion and timing counts on it
//  gameover  in   1   level: freeze the character
//  key_up    in   1   level, debounced
//  key_down  in   1   level, debounced
//  key_left  in   1   level, debounced
//  key_right in   1   level, debounced
//  key_atk   in   1   level, debounced; rising edge requests an attack
//  state     out  4   character state code (below)
//  pos_h     out  10  character x (pixels)
//  pos_v     out  10  character y (pixels)
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Codes: IDLE_F=0 IDLE_B=1 IDLE_L=2 IDLE_R=3 (face down/up/left/right); WALK_F..WALK_R=4..7;
//   DEAD=8; ATK_UP=A (weapon at v-20); ATK_DN=B (v+20); ATK_R=C (h+20); ATK_L=D (h-20).
//  Reset: state=IDLE_F, pos_h=H_INIT, pos_v=V_INIT, atk/cd counters=0, key_atk edge register=0.
//  Outputs are registered: a key change is reflected in state one clk after it is sampled.
//  Attack request: key_atk & ~key_atk_q, sampled every clk, not only on tick. Held key never retriggers.
//  The request is accepted only when not attacking, cd==0, and not DEAD. Requests that are not accepted
//   are dropped, not queued.
//  On accept: state <= ATK code for the current facing (F->B, B->A, L->D, R->C); atk <= ATK_TICKS.
//  ATTACK: no motion. Each tick decrements atk. On the tick where atk==1: state <= IDLE of the same
//   facing, cd <= CD_TICKS. Cooldown decrements on each tick until it reaches 0.
//  Move (not attacking, not DEAD): direction priority up>down>left>right. On tick with a key held:
//   state <= WALK facing, pos += STEP in that direction. With no key held: state <= IDLE of the
//   last facing. Facing updates on key-down even between ticks; position updates only on tick.
//  Clamp: compute next position in 11-bit signed, then saturate to [MIN,MAX]. Never wraps.
//   At pos_h=H_MIN with left held: facing and WALK_L update, pos_h stays.
//  Same cycle, attack edge + direction key: attack wins and facing is not changed that cycle.
//  Same cycle, attack edge + tick: accept, atk loads ATK_TICKS, and that tick does not decrement it.
//  gameover=1 (priority over everything except rst): state <= DEAD, position frozen, counters cleared.
//   DEAD is left only by rst. An attack in progress is aborted, so the weapon sees 8 and goes EMPTY.
//  rst mid-attack or mid-move returns to reset values on the next edge.
// STRUCTURE
//  Shared include/package chunyi_defs: state codes (IDLE_*, WALK_*, DEAD, ATK_*), shared with the
//   weapon stage and the renderer; also screen bounds and WEAPON_OFS=20.
//  One sub-module: rise_edge (1-bit registered rising-edge detector, clk/rst) for key_atk.
//  Rest is one FSM (IDLE/WALK/ATTACK/DEAD) plus atk/cd counters and the clamp adders.
// TESTING
//  1 rst, no keys, 5 ticks -> state=0, pos=(320,240) throughout.
//  2 key_right held 10 ticks -> state=7, pos_h=340, pos_v=240; release -> state=3 next tick.
//  3 key_up + key_atk edge facing up -> state=A for exactly 15 ticks, then state=1. A second
//    edge during the 10-tick cooldown -> ignored; an edge after cooldown -> state=A.
//  4 Start at pos_h=22, hold left 5 ticks -> pos_h 20, then stays 20; state=6.
//  5 gameover asserted mid-attack (state=C) -> state=8 next clk, pos frozen, keys ignored;
//    rst -> state=0, pos=(320,240).
//  6 key_atk held 40 ticks -> exactly one attack; up+left held together -> moves up only (state=5).

Source files
------------

// File: rtl/chunyi_ctrl_pkg.sv
// Shared definitions for the Chun-Yi character: state codes, facing, screen bounds
// and helpers used by the controller, weapon stage and renderer.
package chunyi_defs;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned SCREEN_H   = 480;
    localparam int unsigned WEAPON_OFS = 20;

    typedef enum logic [3:0] {
        IDLE_F = 4'h0,
        IDLE_B = 4'h1,
        IDLE_L = 4'h2,
        IDLE_R = 4'h3,
        WALK_F = 4'h4,
        WALK_B = 4'h5,
        WALK_L = 4'h6,
        WALK_R = 4'h7,
        DEAD   = 4'h8,
        ATK_UP = 4'hA,
        ATK_DN = 4'hB,
        ATK_R  = 4'hC,
        ATK_L  = 4'hD
    } state_t;

    typedef enum logic [1:0] {
        FACE_F = 2'd0,
        FACE_B = 2'd1,
        FACE_L = 2'd2,
        FACE_R = 2'd3
    } face_t;

    function automatic state_t idle_code(input face_t f);
        case (f)
            FACE_F:  return IDLE_F;
            FACE_B:  return IDLE_B;
            FACE_L:  return IDLE_L;
            default: return IDLE_R;
        endcase
    endfunction

    function automatic state_t walk_code(input face_t f);
        case (f)
            FACE_F:  return WALK_F;
            FACE_B:  return WALK_B;
            FACE_L:  return WALK_L;
            default: return WALK_R;
        endcase
    endfunction

    // Facing down swings the weapon below (ATK_DN), facing up swings it above (ATK_UP).
    function automatic state_t atk_code(input face_t f);
        case (f)
            FACE_F:  return ATK_DN;
            FACE_B:  return ATK_UP;
            FACE_L:  return ATK_L;
            default: return ATK_R;
        endcase
    endfunction

    function automatic logic [9:0] clamp10(input logic signed [10:0] v,
                                           input int unsigned lo,
                                           input int unsigned hi);
        int s;
        s = int'(v);
        if (s < int'(lo))      return 10'(lo);
        else if (s > int'(hi)) return 10'(hi);
        else                   return 10'(s);
    endfunction

endpackage

// File: rtl/chunyi_ctrl_rise_edge.sv
// Registered 1-bit rising-edge detector; pulse is high for the cycle d first reads 1.
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic q;

    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    assign pulse = d & ~q;

endmodule

// File: rtl/chunyi_ctrl.sv
// Chun-Yi player controller: turns keys and frame ticks into state code and clamped position.
module chunyi_ctrl
    import chunyi_defs::*;
#(
    parameter int unsigned H_INIT    = 320,
    parameter int unsigned V_INIT    = 240,
    parameter int unsigned H_MIN     = WEAPON_OFS,
    parameter int unsigned H_MAX     = SCREEN_W - WEAPON_OFS - 1,
    parameter int unsigned V_MIN     = WEAPON_OFS,
    parameter int unsigned V_MAX     = SCREEN_H - WEAPON_OFS - 1,
    parameter int unsigned STEP      = 2,
    parameter int unsigned ATK_TICKS = 15,
    parameter int unsigned CD_TICKS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       gameover,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_atk,
    output logic [3:0] state,
    output logic [9:0] pos_h,
    output logic [9:0] pos_v
);

    localparam int unsigned ATK_W = $clog2(ATK_TICKS + 1);
    localparam int unsigned CD_W  = $clog2(CD_TICKS + 1);

    state_t           state_q, state_n;
    face_t            face_q, face_n;
    logic [9:0]       h_q, h_n, v_q, v_n;
    logic [ATK_W-1:0] atk_q, atk_n;
    logic [CD_W-1:0]  cd_q, cd_n;
    logic             atk_req;
    logic             any_key;
    face_t            dir;
    logic signed [10:0] h_ext, v_ext, step_s;

    rise_edge u_atk_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (key_atk),
        .pulse (atk_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_F;
            face_q  <= FACE_F;
            h_q     <= 10'(H_INIT);
            v_q     <= 10'(V_INIT);
            atk_q   <= '0;
            cd_q    <= '0;
        end else begin
            state_q <= state_n;
            face_q  <= face_n;
            h_q     <= h_n;
            v_q     <= v_n;
            atk_q   <= atk_n;
            cd_q    <= cd_n;
        end
    end

    assign any_key = key_up | key_down | key_left | key_right;
    assign h_ext   = $signed({1'b0, h_q});
    assign v_ext   = $signed({1'b0, v_q});
    assign step_s  = $signed(11'(STEP));

    always_comb begin
        if (key_up)        dir = FACE_B;
        else if (key_down) dir = FACE_F;
        else if (key_left) dir = FACE_L;
        else               dir = FACE_R;
    end

    // Priority: gameover > DEAD hold > running attack > new attack > movement.
    always_comb begin
        state_n = state_q;
        face_n  = face_q;
        h_n     = h_q;
        v_n     = v_q;
        atk_n   = atk_q;
        cd_n    = cd_q;
        if (gameover) begin
            state_n = DEAD;
            atk_n   = '0;
            cd_n    = '0;
        end else if (state_q == DEAD) begin
            state_n = DEAD;
        end else if (atk_q != '0) begin
            if (tick) begin
                if (atk_q == ATK_W'(1)) begin
                    state_n = idle_code(face_q);
                    atk_n   = '0;
                    cd_n    = CD_W'(CD_TICKS);
                end else begin
                    atk_n = atk_q - 1'b1;
                end
            end
        end else if (atk_req && cd_q == '0) begin
            state_n = atk_code(face_q);
            atk_n   = ATK_W'(ATK_TICKS);
        end else begin
            if (any_key) face_n = dir;
            if (tick) begin
                if (cd_q != '0) cd_n = cd_q - 1'b1;
                if (any_key) begin
                    state_n = walk_code(dir);
                    case (dir)
                        FACE_B:  v_n = clamp10(v_ext - step_s, V_MIN, V_MAX);
                        FACE_F:  v_n = clamp10(v_ext + step_s, V_MIN, V_MAX);
                        FACE_L:  h_n = clamp10(h_ext - step_s, H_MIN, H_MAX);
                        default: h_n = clamp10(h_ext + step_s, H_MIN, H_MAX);
                    endcase
                end else begin
                    state_n = idle_code(face_q);
                end
            end
        end
    end

    assign state = state_q;
    assign pos_h = h_q;
    assign pos_v = v_q;

endmodule

// File: tb/tb_chunyi_ctrl.sv
// Directed self-checking bench for chunyi_ctrl with hand-computed expectations.
module tb_chunyi_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       gameover = 1'b0;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       key_atk = 1'b0;
    logic [3:0] state;
    logic [9:0] pos_h;
    logic [9:0] pos_v;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned b_count;

    chunyi_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .gameover  (gameover),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_atk   (key_atk),
        .state     (state),
        .pos_h     (pos_h),
        .pos_v     (pos_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clk_n(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_n(input int unsigned n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk_n(2);
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset state held across idle ticks
        clk_n(1);
        do_reset();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_h", 16'(pos_h), 16'd320);
        chk("rst_v", 16'(pos_v), 16'd240);
        tick_n(5);
        chk("idle5_state", 16'(state), 16'd0);
        chk("idle5_h", 16'(pos_h), 16'd320);

        // 2: walk right 10 ticks, then release
        key_right = 1'b1;
        tick_n(10);
        chk("walkr_state", 16'(state), 16'd7);
        chk("walkr_h", 16'(pos_h), 16'd340);
        chk("walkr_v", 16'(pos_v), 16'd240);
        key_right = 1'b0;
        tick_n(1);
        chk("idler_state", 16'(state), 16'd3);

        // 3: face up, attack, cooldown behaviour
        key_up = 1'b1;
        tick_n(1);
        chk("walkb_state", 16'(state), 16'd5);
        chk("walkb_v", 16'(pos_v), 16'd238);
        key_up = 1'b0;
        key_atk = 1'b1;
        clk_n(1);
        chk("atk_up_start", 16'(state), 16'hA);
        key_atk = 1'b0;
        tick_n(14);
        chk("atk_up_t14", 16'(state), 16'hA);
        tick_n(1);
        chk("atk_up_end", 16'(state), 16'd1);
        chk("atk_no_move", 16'(pos_v), 16'd238);
        key_atk = 1'b1;
        clk_n(1);
        chk("cd_ignore0", 16'(state), 16'd1);
        key_atk = 1'b0;
        tick_n(9);
        key_atk = 1'b1;
        clk_n(1);
        chk("cd_ignore9", 16'(state), 16'd1);
        key_atk = 1'b0;
        tick_n(1);
        key_atk = 1'b1;
        clk_n(1);
        chk("cd_done_atk", 16'(state), 16'hA);
        key_atk = 1'b0;
        tick_n(25);

        // 4: left clamp at H_MIN
        do_reset();
        key_left = 1'b1;
        tick_n(149);
        chk("left_22", 16'(pos_h), 16'd22);
        tick_n(1);
        chk("left_20", 16'(pos_h), 16'd20);
        tick_n(4);
        chk("left_clamp", 16'(pos_h), 16'd20);
        chk("left_state", 16'(state), 16'd6);
        key_left = 1'b0;

        // 5: gameover during an attack, then reset
        do_reset();
        key_right = 1'b1;
        tick_n(1);
        chk("go_walk_h", 16'(pos_h), 16'd322);
        key_right = 1'b0;
        key_atk = 1'b1;
        clk_n(1);
        chk("go_atk_r", 16'(state), 16'hC);
        key_atk = 1'b0;
        tick_n(3);
        gameover = 1'b1;
        clk_n(1);
        chk("go_dead", 16'(state), 16'd8);
        key_left = 1'b1;
        key_atk = 1'b1;
        tick_n(3);
        chk("go_dead_keys", 16'(state), 16'd8);
        chk("go_frozen_h", 16'(pos_h), 16'd322);
        chk("go_frozen_v", 16'(pos_v), 16'd240);
        gameover = 1'b0;
        key_left = 1'b0;
        key_atk = 1'b0;
        tick_n(2);
        chk("dead_sticky", 16'(state), 16'd8);
        do_reset();
        chk("go_rst_state", 16'(state), 16'd0);
        chk("go_rst_h", 16'(pos_h), 16'd320);
        chk("go_rst_v", 16'(pos_v), 16'd240);

        // 6: held attack key fires once; up beats left
        key_atk = 1'b1;
        clk_n(1);
        chk("hold_atk_dn", 16'(state), 16'hB);
        b_count = 0;
        for (int i = 0; i < 40; i++) begin
            if (state == 4'hB) b_count++;
            tick_n(1);
        end
        chk("hold_atk_len", 16'(b_count), 16'd15);
        chk("hold_atk_end", 16'(state), 16'd0);
        key_atk = 1'b0;
        key_up = 1'b1;
        key_left = 1'b1;
        tick_n(1);
        chk("prio_state", 16'(state), 16'd5);
        chk("prio_v", 16'(pos_v), 16'd238);
        chk("prio_h", 16'(pos_h), 16'd320);
        key_up = 1'b0;
        key_left = 1'b0;

        // attack edge coinciding with a tick: tick must not consume an attack count
        do_reset();
        @(negedge clk);
        tick = 1'b1;
        key_atk = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        key_atk = 1'b0;
        chk("edge_tick_atk", 16'(state), 16'hB);
        tick_n(14);
        chk("edge_tick_t14", 16'(state), 16'hB);
        tick_n(1);
        chk("edge_tick_end", 16'(state), 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
